// File: rtl/pe_pkg.sv
// Shared defaults for the PE array datapath and the psum drain FSM states.
package pe_pkg;

  localparam int IFMAP_WIDTH  = 8;
  localparam int WEIGHT_WIDTH = 8;
  // Product width plus 3 guard bits for the 8-deep accumulation.
  localparam int PSUM_WIDTH   = IFMAP_WIDTH + WEIGHT_WIDTH + 3;
  localparam int OUT_WIDTH    = 8;
  localparam int FRAC_SHIFT   = 7;
  localparam int NUM_PE       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantizer: sign-extend, optional round-half-up, arithmetic
// shift right, saturate to signed OUT_WIDTH. Rounding enabled by PSUM_DRAIN_ROUND_EN.
module psum_requant #(
  parameter int PSUM_WIDTH = pe_pkg::PSUM_WIDTH,
  parameter int OUT_WIDTH  = pe_pkg::OUT_WIDTH,
  parameter int FRAC_SHIFT = pe_pkg::FRAC_SHIFT
) (
  input  logic [PSUM_WIDTH-1:0] psum_i,
  output logic [OUT_WIDTH-1:0]  data_o
);

  // One extra bit keeps the rounding add from overflowing at the positive extreme.
  localparam int EXT_W = PSUM_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef PSUM_DRAIN_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(1 <<< (FRAC_SHIFT - 1));
`else
  localparam logic signed [EXT_W-1:0] RND = '0;
`endif

  logic signed [EXT_W-1:0] ext_s;
  logic signed [EXT_W-1:0] biased_s;
  logic signed [EXT_W-1:0] shifted_s;

  assign ext_s     = $signed({psum_i[PSUM_WIDTH-1], psum_i});
  assign biased_s  = ext_s + RND;
  assign shifted_s = biased_s >>> FRAC_SHIFT;

  always_comb begin
    if (shifted_s > SAT_MAX) begin
      data_o = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted_s < SAT_MIN) begin
      data_o = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      data_o = shifted_s[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pe_psum_drain.sv
// Captures one PE row's psum bank and streams requantized values over valid/ready.
// Optional round-half-up requantization via PSUM_DRAIN_ROUND_EN.
module pe_psum_drain #(
  parameter  int NUM_PE     = pe_pkg::NUM_PE,
  parameter  int PSUM_WIDTH = pe_pkg::PSUM_WIDTH,
  parameter  int OUT_WIDTH  = pe_pkg::OUT_WIDTH,
  parameter  int FRAC_SHIFT = pe_pkg::FRAC_SHIFT,
  localparam int IDX_W      = $clog2(NUM_PE)
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         capture_i,
  input  logic [NUM_PE*PSUM_WIDTH-1:0] psum_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [OUT_WIDTH-1:0]         out_data_o,
  output logic [IDX_W-1:0]             out_idx_o,
  output logic                         out_last_o
);

  import pe_pkg::*;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic                 last;
    logic [IDX_W-1:0]     idx;
    logic [OUT_WIDTH-1:0] data;
  } drain_out_t;

  drain_state_t          state_q;
  drain_out_t            out_q;
  logic [PSUM_WIDTH-1:0] bank_q [NUM_PE];

  logic                  hs;
  logic [IDX_W-1:0]      idx_inc;
  logic [IDX_W-1:0]      sel_idx;
  logic [PSUM_WIDTH-1:0] req_psum;
  logic [OUT_WIDTH-1:0]  req_data;

  assign hs      = out_q.valid & out_ready_i;
  assign idx_inc = out_q.idx + IDX_W'(1);
  assign sel_idx = out_q.last ? out_q.idx : idx_inc;

  // The requantizer always computes the element to present after the next edge:
  // PE0 straight from the input bus on capture, otherwise the following bank entry.
  assign req_psum = (state_q == STREAM) ? bank_q[sel_idx] : psum_i[PSUM_WIDTH-1:0];

  psum_requant #(
    .PSUM_WIDTH (PSUM_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_requant (
    .psum_i (req_psum),
    .data_o (req_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      out_q   <= '0;
      // NOTE: the bank is a small register file, not RAM, so it is safe to
      // reset; it is cleared so an abandoned transaction leaves no stale data.
      for (int i = 0; i < NUM_PE; i++) bank_q[i] <= '0;
    end else if (!en) begin
      state_q <= IDLE;
      out_q   <= '0;
      for (int i = 0; i < NUM_PE; i++) bank_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_i) begin
            for (int i = 0; i < NUM_PE; i++) bank_q[i] <= psum_i[i*PSUM_WIDTH +: PSUM_WIDTH];
            state_q     <= STREAM;
            out_q.busy  <= 1'b1;
            out_q.done  <= 1'b0;
            out_q.valid <= 1'b1;
            out_q.last  <= (NUM_PE == 1);
            out_q.idx   <= '0;
            out_q.data  <= req_data;
          end
        end
        STREAM: begin
          if (hs) begin
            if (out_q.last) begin
              state_q     <= DONE;
              out_q.busy  <= 1'b0;
              out_q.done  <= 1'b1;
              out_q.valid <= 1'b0;
              out_q.last  <= 1'b0;
              out_q.idx   <= '0;
              out_q.data  <= '0;
            end else begin
              out_q.idx  <= idx_inc;
              out_q.last <= (idx_inc == IDX_W'(NUM_PE - 1));
              out_q.data <= req_data;
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          out_q.done <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          out_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o      = out_q.busy;
  assign done_o      = out_q.done;
  assign out_valid_o = out_q.valid;
  assign out_last_o  = out_q.last;
  assign out_idx_o   = out_q.idx;
  assign out_data_o  = out_q.data;

endmodule
